// File: rtl/fir_stream_engine.sv
// fir_stream_engine: streaming fixed-point FIR filter.
// Each accepted sample starts one pass over the first nt taps. The pass
// performs one multiply per cycle into a registered product, then a drain
// cycle folds in the last product. The result is rounded, saturated and
// held on the output until downstream takes it. Coefficients live in a
// small RAM that can only be rewritten while the engine is idle.
module fir_stream_engine #(
  parameter  int DATA_W    = 16,
  parameter  int COEF_W    = 16,
  parameter  int TAPS      = 64,
  parameter  int OUT_SHIFT = 15,
  localparam int ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(TAPS):0]     num_taps,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  output logic                      coef_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sat,
  output logic                      busy
);

  localparam int AW      = $clog2(TAPS);
  localparam int NW      = AW + 1;
  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int HALF_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic [NW-1:0] TAPS_N    = NW'(TAPS);
  localparam logic [AW-1:0] TAPS_LAST = AW'(TAPS - 1);

  // Rounding offset: half an output LSB, or nothing when there is no shift.
  localparam logic signed [ACC_W:0] ONE_W = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] HALF  = (OUT_SHIFT > 0) ? (ONE_W <<< HALF_SH) : '0;

  // Output clipping limits, expressed at the widened accumulator width.
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT
  } state_t;

  state_t state;
  state_t next_state;

  // Storage: coefficient RAM and circular sample history.
  logic signed [COEF_W-1:0] coef_ram [TAPS];
  logic signed [DATA_W-1:0] hist     [TAPS];

  // Pass bookkeeping.
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] base_ptr;
  logic [NW-1:0] sample_cnt;
  logic [NW-1:0] nt;
  logic [NW-1:0] k;

  // Arithmetic pipeline.
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] tap_prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    acc_wide;
  logic signed [ACC_W:0]    rounded;

  // Decoded control.
  logic          accept;
  logic          coef_ok;
  logic          tap_live;
  logic          last_tap;
  logic [NW-1:0] nt_clamped;
  logic [AW-1:0] coef_idx;
  logic [AW-1:0] hist_idx;

  // Decode the input handshake, the write qualification and the tap clamp.
  always_comb begin
    accept  = in_valid && (state == IDLE);
    coef_ok = coef_we && (state == IDLE) && ({1'b0, coef_addr} < TAPS_N);
    if (num_taps == '0) begin
      nt_clamped = NW'(1);
    end else if (num_taps > TAPS_N) begin
      nt_clamped = TAPS_N;
    end else begin
      nt_clamped = num_taps;
    end
  end

  // Locate tap k: coefficient k and the sample k steps older than the newest.
  always_comb begin
    coef_idx = k[AW-1:0];
    if ({1'b0, base_ptr} >= k) begin
      hist_idx = AW'({1'b0, base_ptr} - k);
    end else begin
      hist_idx = AW'({1'b0, base_ptr} + TAPS_N - k);
    end
    tap_live = (k < sample_cnt);
    last_tap = (k == (nt - NW'(1)));
    tap_prod = PROD_W'(coef_ram[coef_idx]) * PROD_W'(hist[hist_idx]);
  end

  // Fold the pending product into the accumulator, then round toward +inf at the half point.
  always_comb begin
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    acc_sum  = acc + prod_ext;
    acc_wide = {acc_sum[ACC_W-1], acc_sum};
    rounded  = (acc_wide + HALF) >>> OUT_SHIFT;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the handshake outputs that depend only on state.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          next_state = MAC;
        end
      end
      MAC: begin
        if (last_tap) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        next_state = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Coefficient RAM: idle-only writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (coef_ok && !rst) begin
      coef_ram[coef_addr] <= coef_data;
    end
  end

  // Sample history: the accepted sample lands at the write pointer.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      hist[wr_ptr] <= in_data;
    end
  end

  // Dropped coefficient writes raise a one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_err <= 1'b0;
    end else begin
      coef_err <= coef_we && !coef_ok;
    end
  end

  // Intake bookkeeping: write pointer, fill level and the pass setup latched at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      base_ptr   <= '0;
      sample_cnt <= '0;
      nt         <= NW'(1);
    end else if (accept) begin
      base_ptr <= wr_ptr;
      wr_ptr   <= (wr_ptr == TAPS_LAST) ? '0 : wr_ptr + AW'(1);
      nt       <= nt_clamped;
      if (sample_cnt != TAPS_N) begin
        sample_cnt <= sample_cnt + NW'(1);
      end
    end
  end

  // Multiply-accumulate pipeline: one tap issued per MAC cycle, last product folded in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      k    <= '0;
      prod <= '0;
      acc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            k    <= '0;
            prod <= '0;
            acc  <= '0;
          end
        end
        MAC: begin
          prod <= tap_live ? tap_prod : '0;
          acc  <= acc_sum;
          k    <= k + NW'(1);
        end
        DRAIN: begin
          acc <= acc_sum;
        end
        default: begin
        end
      endcase
    end
  end

  // Result register: clip the rounded sum as the pass leaves DRAIN, hold it through OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (state == DRAIN) begin
      if (rounded > SAT_MAX) begin
        out_data <= SAT_MAX[DATA_W-1:0];
        out_sat  <= 1'b1;
      end else if (rounded < SAT_MIN) begin
        out_data <= SAT_MIN[DATA_W-1:0];
        out_sat  <= 1'b1;
      end else begin
        out_data <= rounded[DATA_W-1:0];
        out_sat  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_engine.sv
// tb_fir_stream_engine: three engines with output shifts 0, 1 and 15 share
// one input stream. Each result is compared with a convolution model that
// works on a plain list of the samples accepted since the last reset.
module tb_fir_stream_engine;

  localparam int TAPS   = 8;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int AW     = $clog2(TAPS);
  localparam int NTW    = AW + 1;

  logic clk = 1'b0;
  logic rst;
  logic [NTW-1:0]    num_taps;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic [2:0] coef_err;
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] out_sat;
  logic [2:0] busy;
  logic [2:0][DATA_W-1:0] out_data_v;

  int shifts [3] = '{0, 1, 15};

  int     coef_m [TAPS];
  int     hist_q [$];
  int     pass_count = 0;
  int     check_count = 0;
  longint last_data [3];
  bit     last_sat [3];

  always #5 clk = ~clk;

  fir_stream_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_SHIFT(0)) dut_sh0 (
    .clk(clk), .rst(rst), .num_taps(num_taps), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err[0]), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data_v[0]),
    .out_sat(out_sat[0]), .busy(busy[0]));

  fir_stream_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_SHIFT(1)) dut_sh1 (
    .clk(clk), .rst(rst), .num_taps(num_taps), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err[1]), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data_v[1]),
    .out_sat(out_sat[1]), .busy(busy[1]));

  fir_stream_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_SHIFT(15)) dut_sh15 (
    .clk(clk), .rst(rst), .num_taps(num_taps), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err[2]), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data_v[2]),
    .out_sat(out_sat[2]), .busy(busy[2]));

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    check_count++;
    if (observed == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int clampTaps(input int n);
    if (n == 0) return 1;
    if (n > TAPS) return TAPS;
    return n;
  endfunction

  // Reference: direct convolution over the accepted samples, then round and clip.
  function automatic longint modelY(input int nt, input int shift, output bit sat);
    longint acc;
    longint r;
    int n;
    acc = 0;
    n = hist_q.size();
    for (int j = 0; j < nt; j++) begin
      if (j < n) acc += longint'(coef_m[j]) * longint'(hist_q[n - 1 - j]);
    end
    if (shift > 0) r = (acc + (longint'(1) << (shift - 1))) >>> shift;
    else r = acc;
    sat = 1'b0;
    if (r > 32767) begin
      r = 32767;
      sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      sat = 1'b1;
    end
    return r;
  endfunction

  function automatic int randVal(input int sel);
    int m;
    m = (sel == 0) ? 100 : (sel == 1) ? 3000 : 32767;
    return int'($urandom_range(0, 2 * m)) - m;
  endfunction

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist_q.delete();
  endtask

  task automatic writeCoef(input int addr, input int value);
    coef_we = 1'b1;
    coef_addr = AW'(addr);
    coef_data = COEF_W'(value);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    coef_m[addr] = value;
  endtask

  // One sample through all engines. stall holds out_ready low in OUT;
  // mode 1 writes a coefficient during MAC, mode 2 in the accept cycle.
  task automatic applyStimulus(input int sample, input int ntaps, input int stall,
                               input int mode, input int caddr, input int cval);
    int     nt_e;
    int     lat;
    bit     done;
    longint exp_y [3];
    bit     exp_s [3];
    nt_e = clampTaps(ntaps);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = DATA_W'(sample);
    num_taps = NTW'(ntaps);
    out_ready = (stall == 0);
    if (mode == 2) begin
      coef_we = 1'b1;
      coef_addr = AW'(caddr);
      coef_data = COEF_W'(cval);
    end
    @(negedge clk);
    checkOutput("in_ready_idle", in_ready, 7);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    if (mode == 2) coef_m[caddr] = cval;
    hist_q.push_back(sample);
    if (hist_q.size() > TAPS) void'(hist_q.pop_front());
    for (int i = 0; i < 3; i++) exp_y[i] = modelY(nt_e, shifts[i], exp_s[i]);
    if (mode == 1) begin
      coef_we = 1'b1;
      coef_addr = AW'(caddr);
      coef_data = COEF_W'(cval);
    end
    lat = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checkOutput("busy_mac", busy[0], 1);
        checkOutput("in_ready_mac", in_ready[0], 0);
      end
      if (mode == 1 && lat == 2) begin
        coef_we = 1'b0;
        checkOutput("coef_err_pulse", coef_err[0], 1);
      end
      if (mode == 1 && lat == 3) checkOutput("coef_err_clear", coef_err[0], 0);
      if (mode == 2 && lat == 1) checkOutput("coef_err_idle_write", coef_err[0], 0);
      if (out_valid[0]) begin
        done = 1'b1;
      end else if (lat > TAPS + 6) begin
        checkOutput("out_valid_timeout", lat, nt_e + 2);
        coef_we = 1'b0;
        out_ready = 1'b1;
        return;
      end
    end
    checkOutput("latency", lat, nt_e + 2);
    checkOutput("out_valid_all", out_valid, 7);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("out_data_sh%0d", shifts[i]), $signed(out_data_v[i]), exp_y[i]);
      checkOutput($sformatf("out_sat_sh%0d", shifts[i]), out_sat[i], exp_s[i]);
      last_data[i] = exp_y[i];
      last_sat[i] = exp_s[i];
    end
    if (stall > 0) begin
      in_valid = 1'b1;
      in_data = DATA_W'(sample + 1);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checkOutput("bp_out_valid", out_valid[0], 1);
        checkOutput("bp_out_data", $signed(out_data_v[0]), exp_y[0]);
        checkOutput("bp_out_sat", out_sat[0], exp_s[0]);
        checkOutput("bp_in_ready", in_ready[0], 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("release_out_valid", out_valid, 0);
    checkOutput("release_in_ready", in_ready[0], 1);
  endtask

  int imp_exp [5] = '{1, 2, 3, 4, 0};
  int pad_exp [5] = '{100, 200, 300, 400, 400};

  initial begin
    rst = 1'b1;
    num_taps = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    for (int i = 0; i < TAPS; i++) coef_m[i] = 0;

    // Reset state.
    doReset();
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 7);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", $signed(out_data_v[0]), 0);
    checkOutput("rst_out_sat", out_sat, 0);
    checkOutput("rst_coef_err", coef_err, 0);
    checkOutput("rst_busy", busy, 0);

    // Impulse response.
    for (int i = 0; i < TAPS; i++) writeCoef(i, (i < 4) ? i + 1 : 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 0) ? 1 : 0, 4, 0, 0, 0, 0);
      checkOutput("impulse_const", last_data[0], imp_exp[i]);
    end

    // Start-up zero padding.
    doReset();
    for (int i = 0; i < TAPS; i++) writeCoef(i, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(100, 4, 0, 0, 0, 0);
      checkOutput("zero_pad_const", last_data[0], pad_exp[i]);
    end

    // Saturation at both rails.
    doReset();
    writeCoef(0, 32767);
    writeCoef(1, 32767);
    applyStimulus(32767, 2, 0, 0, 0, 0);
    applyStimulus(32767, 2, 0, 0, 0, 0);
    checkOutput("sat_pos_data", last_data[0], 32767);
    checkOutput("sat_pos_flag", last_sat[0], 1);
    applyStimulus(-32767, 2, 0, 0, 0, 0);
    applyStimulus(-32767, 2, 0, 0, 0, 0);
    checkOutput("sat_neg_data", last_data[0], -32768);
    checkOutput("sat_neg_flag", last_sat[0], 1);

    // Rounding with a one-bit shift.
    doReset();
    writeCoef(0, 3);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("round_pos", last_data[1], 2);
    applyStimulus(-1, 1, 0, 0, 0, 0);
    checkOutput("round_neg", last_data[1], -1);

    // Backpressure, then a follow-up that shows the pending sample was not taken.
    for (int i = 0; i < TAPS; i++) writeCoef(i, i + 1);
    applyStimulus(500, 4, 5, 0, 0, 0);
    applyStimulus(-250, 4, 0, 0, 0, 0);

    // Tap-count clamp and latency.
    applyStimulus(700, 1, 0, 0, 0, 0);
    applyStimulus(800, 0, 0, 0, 0, 0);
    applyStimulus(900, TAPS + 5, 0, 0, 0, 0);

    // Coefficient write in MAC is dropped; write in the accept cycle is used.
    applyStimulus(200, 4, 0, 1, 0, 999);
    applyStimulus(300, 4, 0, 2, 1, -77);

    // Reset in the middle of a pass.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = DATA_W'(1234);
    num_taps = NTW'(TAPS);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist_q.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 7);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_data", $signed(out_data_v[0]), 0);
    for (int i = 0; i < TAPS; i++) writeCoef(i, (i < 4) ? i + 1 : 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 0) ? 1 : 0, 4, 0, 0, 0, 0);
      checkOutput("midrst_impulse", last_data[0], imp_exp[i]);
    end

    // Randomized traffic.
    doReset();
    for (int i = 0; i < TAPS; i++) writeCoef(i, randVal(int'($urandom_range(0, 2))));
    for (int t = 0; t < 40; t++) begin
      int mode;
      if ($urandom_range(0, 3) == 0)
        writeCoef(int'($urandom_range(0, TAPS - 1)), randVal(int'($urandom_range(0, 2))));
      mode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      applyStimulus(randVal(int'($urandom_range(0, 2))), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), mode, int'($urandom_range(0, TAPS - 1)),
                    randVal(int'($urandom_range(0, 2))));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fir_stream_engine.md
Name: fir_stream_engine

Overview:
Parametrised, streaming fixed-point FIR engine. It computes y[n] = sum over k = 0..num_taps-1 of b[k]*x[n-k], where x[n-k] for n-k < 0 is zero. Samples arrive on a valid/ready stream, coefficients load through a write port, and the output is rounded and saturated, one result per accepted sample. It is the generalised successor to the fixed 50-tap, 1000-sample filter sequencer: it runs in continuous stream mode with a runtime tap count and backpressure.

Parameters:
DATA_W, 16, signed sample and output width
COEF_W, 16, signed coefficient width
TAPS, 64, maximum tap count; coefficient RAM and sample history depth
OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before saturation
ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
num_taps  in  $clog2(TAPS)+1  active tap count, sampled at accept
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  coefficient index k
coef_data  in  COEF_W  signed b[k]
coef_err  out  1  one-cycle pulse when a coefficient write is dropped
in_valid  in  1  sample valid
in_ready  out  1  engine can accept a sample
in_data  in  DATA_W  signed x[n]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  DATA_W  signed y[n]
out_sat  out  1  out_data was clipped; qualified by out_valid
busy  out  1  state is not IDLE

Behaviour:
- Reset: state IDLE. in_ready=1, out_valid=0, out_data=0, out_sat=0, coef_err=0, busy=0. Write pointer=0, sample count=0. Coefficient RAM is not cleared. Reset mid-MAC or mid-OUT aborts with no output.
- States: IDLE -> MAC -> DRAIN -> OUT -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - store in_data at history[wr_ptr]; wr_ptr advances modulo TAPS;
  - sample count saturates at TAPS;
  - latch nt = clamp(num_taps, 1, TAPS), with 0 treated as 1;
  - clear the accumulator; go to MAC.
- MAC: one tap per cycle for k = 0..nt-1.
  - Read b[k] and x[n-k] (history index wr_ptr_at_accept - k, modulo TAPS).
  - If k >= sample count, the product is forced to 0, which gives start-up zero-padding.
  - Product is a full-precision signed COEF_W+DATA_W register (one pipeline stage); it is added into the ACC_W accumulator the following cycle.
  - After the nt-th issue, go to DRAIN.
- DRAIN: one cycle; the final product is accumulated.
- Round and saturate, registered on the DRAIN->OUT transition:
  - r = (acc + (OUT_SHIFT>0 ? 1<<(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT;
  - clip r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat=1 if clipped.
- OUT: out_valid=1. out_data and out_sat are held stable until out_valid&&out_ready, then go to IDLE with out_valid=0 on the next cycle.
- Latency: out_valid rises nt+2 cycles after the accept edge. Throughput is one sample per nt+3 cycles with out_ready held high.
- in_ready=0 in every state except IDLE, so no sample is lost or overwritten under backpressure.
- Coefficient writes:
  - take effect the next cycle, and only when the state is IDLE;
  - a coef_we outside IDLE is dropped and coef_err pulses for one cycle;
  - if coef_we and an accept occur in the same IDLE cycle, the write completes first and the new value is used for that sample;
  - coef_addr >= TAPS is dropped with coef_err.
- A change to num_taps between samples applies from the next accept. History beyond the old tap count remains valid.
- Accumulator never wraps: ACC_W covers the worst case of TAPS full-scale products.

Test Plan:
- Impulse: OUT_SHIFT=0, nt=4, b={1,2,3,4}, samples 1,0,0,0,0 -> out_data 1,2,3,4,0, out_sat=0.
- Zero-padding: b all 1, nt=4, first samples 100,100,100,100,100 -> 100,200,300,400,400.
- Saturation and rounding:
  - OUT_SHIFT=0, b={32767,32767}, samples 32767 x2 -> second output 32767 with out_sat=1; negated samples -> -32768 with out_sat=1.
  - OUT_SHIFT=1, acc 3 -> 2; acc -3 -> -1.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid, out_data and out_sat stable, in_ready=0, a pending in_valid is not accepted. Release out_ready -> in_ready=1 the cycle after the handshake.
- Latency and tap clamp: nt=1 -> out_valid 3 cycles after accept; num_taps=0 behaves as 1; num_taps=TAPS+5 behaves as TAPS (out_valid TAPS+2 cycles after accept).
- Control corner cases:
  - coef_we during MAC -> coef_err pulse, coefficient unchanged.
  - rst asserted mid-MAC -> next cycle idle outputs; the next impulse response matches a fresh start.
